// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder (a + b + cin -> {cout, s}), one full-adder cell plus carry flop, LSB first.
// Latency: done pulses WIDTH+1 cycles after the start edge; busy is high for exactly WIDTH cycles.
// Backpressure: start is only honoured in IDLE; requests while busy are dropped, s/cout hold until the next completion.
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam int PW = WIDTH - 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [PW-1:0]    psum_q, psum_d;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             load, step, finish;
    logic             sum_bit, carry_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load   = (state_q == IDLE) && start;
        step   = (state_q == RUN);
        finish = step && (cnt_q == LAST);
    end

    // The single full-adder cell; the partial sum holds the low WIDTH-1 bits, the top bit arrives on the final step.
    always_comb begin
        sum_bit = a_sr[0] ^ b_sr[0] ^ carry_q;
        carry_d = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry_q) | (b_sr[0] & carry_q);
        psum_d  = (psum_q >> 1) | (PW'(sum_bit) << (PW - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            psum_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            s       <= '0;
            cout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                a_sr    <= a;
                b_sr    <= b;
                carry_q <= cin;
                psum_q  <= '0;
                cnt_q   <= '0;
                busy    <= 1'b1;
            end else if (step) begin
                a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
                b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
                carry_q <= carry_d;
                psum_q  <= psum_d;
                cnt_q   <= cnt_q + 1'b1;
                if (finish) begin
                    s    <= {sum_bit, psum_q};
                    cout <= carry_d;
                    busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=4): latency, wrap-around, ignored start, streaming scoreboard, resets.
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a, b;
    logic       cin;
    logic [3:0] s;
    logic       cout, busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    serial_adder #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .s     (s),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_add(input string tag, input logic [3:0] av, input logic [3:0] bv,
                          input logic cv, input logic [3:0] es, input logic ec);
        int busy_cnt;
        int cyc;
        a = av; b = bv; cin = cv; start = 1'b1;
        tick;
        start = 1'b0;
        a = ~av; b = ~bv; cin = ~cv;
        busy_cnt = 0;
        cyc = 0;
        while (!done && cyc < 20) begin
            if (busy) busy_cnt++;
            tick;
            cyc++;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busycycles"}, busy_cnt, 4);
        chk({tag, "_s"}, s, es);
        chk({tag, "_cout"}, cout, ec);
        chk({tag, "_busy_at_done"}, busy, 0);
        tick;
        chk({tag, "_done_one_cycle"}, done, 0);
    endtask

    logic [8:0] q[$];
    logic [8:0] v, vec;
    logic [4:0] e;
    logic       exp_done;
    int         rem, nres, ndone, done_idx;
    logic [3:0] cap_s;
    logic       cap_c;

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick;
        tick;
        chk("rst_s", s, 0);
        chk("rst_cout", cout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        tick;

        do_add("add_7_5", 4'b0111, 4'b0101, 1'b0, 4'b1100, 1'b0);
        do_add("add_f_1", 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1);
        do_add("add_f_f_1", 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1);
        chk("hold_s_idle", s, 4'b1111);

        // Second start two cycles into the run must be dropped
        a = 4'b0011; b = 4'b0010; cin = 1'b0; start = 1'b1;
        tick;
        start = 1'b0; a = 4'b1111; b = 4'b1111;
        tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("ign_busy", busy, 1);
        ndone = 0; done_idx = -1; cap_s = '0; cap_c = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (done) begin
                ndone++;
                done_idx = i;
                cap_s = s;
                cap_c = cout;
            end
        end
        chk("ign_ndone", ndone, 1);
        chk("ign_done_time", done_idx, 1);
        chk("ign_s", cap_s, 4'b0101);
        chk("ign_cout", cap_c, 0);

        // Async reset two edges into a run, then one full cycle of reset
        a = 4'b0111; b = 4'b0101; cin = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        #3 rst = 1'b1;
        #1;
        chk("arst_s", s, 0);
        chk("arst_cout", cout, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        tick;
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (done || busy) ndone++;
        end
        chk("arst_no_done", ndone, 0);
        chk("arst_s_after", s, 0);
        do_add("post_rst_1_1_1", 4'b0001, 4'b0001, 1'b1, 4'b0011, 1'b0);

        // Start held high, operands change every cycle; only every 5th vector is captured
        rem = 0; nres = 0;
        for (int t = 0; t < 2565; t++) begin
            start = (t < 2560);
            v = (t % 5 == 0) ? 9'(t / 5) : 9'((t * 73) % 512);
            {a, b, cin} = v;
            exp_done = 1'b0;
            if (rem == 0) begin
                if (start) begin
                    q.push_back(v);
                    rem = 4;
                end
            end else begin
                rem--;
                if (rem == 0) exp_done = 1'b1;
            end
            tick;
            chk("stream_done", done, exp_done);
            if (done && q.size() > 0) begin
                vec = q.pop_front();
                e = 5'(vec[8:5]) + 5'(vec[4:1]) + 5'(vec[0]);
                chk("stream_sum", {cout, s}, e);
                nres++;
            end
        end
        chk("stream_count", nres, 512);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder with carry-in and carry-out.
- It is the addition-side counterpart to the team's combinational ripple-borrow subtractor (a, b, bin -> d, bout).
- On a start pulse it latches its operands, then resolves one sum bit per clock, LSB first, through a single full-adder cell and a carry flip-flop.
- It reports the registered sum and carry with a one-cycle done pulse. Used where area matters more than latency, and as a sequential reference for checking the combinational arithmetic blocks.

Parameters:
WIDTH, 4, operand and sum width in bits (legal range 2..16).

Ports:
clk    input   1      rising-edge clock
rst    input   1      asynchronous reset, active-high
start  input   1      request an addition; sampled on rising clk edge
a      input   WIDTH  augend, captured on accepted start
b      input   WIDTH  addend, captured on accepted start
cin    input   1      carry-in, captured on accepted start
s      output  WIDTH  registered sum of the last completed addition
cout   output  1      registered carry-out of the last completed addition
busy   output  1      high while an addition is in progress
done   output  1      one-cycle pulse: s/cout just updated

Behaviour:
- Reset (rst=1, asynchronous, active-high): state=IDLE; s=0, cout=0, busy=0, done=0. Operand shift registers, carry flip-flop and bit counter are all cleared. Reset dominates every other input.
- State machine has two states, IDLE and RUN.
- IDLE:
  - done is deasserted on every edge unless that edge completes a RUN.
  - If start=1 at an edge, the block captures a into shift register A, b into shift register B, and cin into the carry flip-flop. It clears the bit counter and the partial-sum register, sets busy=1 and moves to RUN.
  - If start=0, it stays in IDLE; s and cout hold.
- RUN, at each edge:
  - sum_bit = A[0] ^ B[0] ^ carry; carry <= majority(A[0], B[0], carry).
  - A and B shift right by one; sum_bit shifts into the MSB of the partial-sum register; the counter increments.
- Completion: on the edge that processes bit WIDTH-1 (the WIDTH-th RUN edge):
  - s <= final partial sum; cout <= final carry.
  - done <= 1, busy <= 0, state <= IDLE.
- Latency: done is high in the cycle after the WIDTH-th edge following the start-sampling edge, i.e. busy is high for exactly WIDTH cycles.
- done stays high for exactly one cycle.
- Arithmetic: {cout, s} == a + b + cin, modulo 2^(WIDTH+1), with an exact match required. Full wrap-around must be handled, e.g. all-ones + all-ones + 1.
- start while busy=1 is ignored. It causes no restart and no operand change, and the in-flight result is unaffected.
- start high in the done cycle is accepted, because the state is already IDLE. Back-to-back throughput is one result per WIDTH+1 cycles.
- a, b and cin may change freely after the start edge; only the captured values are used.
- s and cout are not cleared at start; they hold the previous result until the next completion.
- Reset mid-RUN aborts the operation: no done pulse, s=0, cout=0, and the next start behaves as after power-up.
- start held high continuously: a new addition is accepted every WIDTH+1 cycles, each with freshly sampled operands.

Test Plan:
- WIDTH=4: reset, then start with a=0111, b=0101, cin=0 -> busy high for 4 cycles; done pulses once; s=1100, cout=0.
- a=1111, b=0001, cin=0 -> s=0000, cout=1. Also a=1111, b=1111, cin=1 -> s=1111, cout=1 (wrap-around and carry-in).
- Start with a=0011, b=0010; pulse start with a=1111, b=1111 two cycles later while busy -> second request ignored; s=0101, cout=0; a single done pulse.
- Hold start high with operands changing every cycle (same a/b increment/decrement pattern as the subtractor bench) -> result every 5 cycles, each equal to the operands captured at its start edge. Scoreboard all 512 {a, b, cin} combinations against a+b+cin.
- Assert rst for one cycle two edges into a RUN -> s=0, cout=0, busy=0, no done pulse. A following start with a=0001, b=0001, cin=1 -> s=0011, cout=0.
- Apply rst asynchronously between clock edges -> outputs clear immediately, before the next clk edge.
